// File: rtl/mul_reduce_add_uint8.sv
// Reduce stage behind the 3-cycle uint8 multiplier.
// Sums ELEMS valid products per group and reports carry-out.
module mul_reduce_add_uint8 #(
  parameter int MUL_LATENCY = 3,
  parameter int ELEMS       = 4,
  parameter int ACC_WIDTH   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [7:0]           prod,
  output logic [ACC_WIDTH-1:0] O,
  output logic                 valid_out,
  output logic                 overflow
);

  localparam int CW = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ELEMS - 1);

  logic [MUL_LATENCY-1:0] vld_d;
  logic                   vld_al;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   ovf_run;
  logic [CW-1:0]          count;
  logic [ACC_WIDTH:0]     prod_ext;
  logic [ACC_WIDTH:0]     sum;
  logic                   carry;

  assign vld_al = vld_d[MUL_LATENCY-1];

  // Narrow accumulators keep only the low product bits.
  generate
    if (ACC_WIDTH >= 8) begin : g_wide
      assign prod_ext = {{(ACC_WIDTH-7){1'b0}}, prod};
    end else begin : g_narrow
      assign prod_ext = {1'b0, prod[ACC_WIDTH-1:0]};
    end
  endgenerate

  assign sum   = {1'b0, acc} + prod_ext;
  assign carry = sum[ACC_WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_d     <= '0;
      acc       <= '0;
      ovf_run   <= 1'b0;
      count     <= '0;
      O         <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      vld_d[0]  <= valid_in;
      for (int i = 1; i < MUL_LATENCY; i++)
        vld_d[i] <= vld_d[i-1];
      valid_out <= 1'b0;
      if (vld_al) begin
        if (count == LAST) begin
          O         <= sum[ACC_WIDTH-1:0];
          overflow  <= ovf_run | carry;
          valid_out <= 1'b1;
          acc       <= '0;
          ovf_run   <= 1'b0;
          count     <= '0;
        end else begin
          acc     <= sum[ACC_WIDTH-1:0];
          ovf_run <= ovf_run | carry;
          count   <= count + 1'b1;
        end
      end
    end
  end

endmodule
